key_operand_mult: RTL
=====================

# key_operand_mult

Downstream consumer of the keypad scanner. Takes one-cycle key events carrying a 4-bit hex code and assembles two WIDTH-bit operands, most significant digit first. After the last digit of operand B it runs a sequential shift-add multiply, one bit per cycle, and holds the 2·WIDTH-bit product for the display stage.

## Interface
- WIDTH, 8: operand width in bits; must be a multiple of 4, range 4..16; DIGITS = WIDTH/4 per operand
- clk  in  1  system clock; all state updates on rising edge
- clr_n  in  1  asynchronous, active-low reset
- key_code  in  4  hex value of pressed key (0x0..0xF)
- key_valid  in  1  one-cycle strobe: key_code is a new press
- clear_entry  in  1  synchronous abort: discard entry, return to IDLE
- op_a  out  WIDTH  operand A as entered so far
- op_b  out  WIDTH  operand B as entered so far
- product  out  2·WIDTH  last completed product
- digit_cnt  out  3  digits accepted in the current entry, 0..2·DIGITS
- busy  out  1  multiply in progress
- prod_valid  out  1  one-cycle pulse when product updates
- overrun  out  1  sticky: a key arrived while busy

## Operation
- States: IDLE, ENTRY_A, ENTRY_B, BUSY, DONE.
- IDLE:
  - key_valid: op_a ← {op_a[WIDTH-5:0], key_code}, digit_cnt ← 1.
  - Go to ENTRY_A, or straight to ENTRY_B when DIGITS = 1.
- ENTRY_A / ENTRY_B:
  - Each key_valid shifts key_code into the low nibble of the current operand and increments digit_cnt.
  - After DIGITS digits in A, go to ENTRY_B.
  - After DIGITS digits in B, go to BUSY and load: accumulator ← 0, multiplicand ← op_a, multiplier ← op_b, iteration counter ← 0.
- BUSY, per cycle:
  - If multiplier LSB = 1: accumulator ← accumulator + (multiplicand << i).
  - Then the multiplier shifts right and i increments.
  - After WIDTH iterations: product ← accumulator, prod_valid ← 1, go to DONE.
- BUSY input handling: key_valid is dropped and sets overrun. clear_entry is honoured.
- DONE:
  - product, op_a and op_b are held.
  - The next key_valid clears op_a, op_b and overrun, takes the key as the first digit of A, sets digit_cnt ← 1, and goes to ENTRY_A (or ENTRY_B when DIGITS = 1).
- clear_entry, any state:
  - Next state IDLE; op_a, op_b, digit_cnt, accumulator and overrun go to 0.
  - product is retained; busy goes low on the same edge.
- clear_entry and key_valid together: clear_entry wins and the key is discarded.
- Width rules:
  - The accumulator is 2·WIDTH bits; the unsigned product can never overflow.
  - digit_cnt does not wrap; it is reset only on the first digit, clear_entry or reset.
- Reset values: state IDLE; op_a, op_b, product, digit_cnt 0; busy, prod_valid, overrun 0.
- Reset mid-BUSY: the computation is abandoned, product is 0, and no prod_valid pulse is issued.

## Timing
- key_valid is sampled at the rising edge; the operand update is visible the cycle after.
- Last digit of B captured at edge T: busy = 1 from T.
- Iterations run at edges T+1 .. T+WIDTH.
- At edge T+WIDTH: product is valid, prod_valid = 1 for exactly one cycle, busy = 0, state is DONE.
- Latency is WIDTH cycles from the last-digit edge to the product edge, independent of operand values.
- No backpressure: the producer must not rely on keys being queued.
- Back-to-back key_valid on consecutive cycles is accepted at one digit per cycle in the entry states.

## Configuration
- KEYMULT_SIGNED_EN defined:
  - op_a and op_b are two's complement.
  - The multiplicand is sign-extended to 2·WIDTH bits.
  - In the final iteration (multiplier MSB) the partial product is subtracted instead of added.
  - The product is a 2·WIDTH-bit signed result. Latency is unchanged.
- KEYMULT_SIGNED_EN not defined: unsigned operands, zero-extended, add-only.

## Test plan
- WIDTH=8, keys 1,2,3,4 on separate cycles:
  - op_a=0x12, op_b=0x34.
  - prod_valid 8 cycles after the '4' edge with product=0x03A8.
- Keys F,F,F,F, unsigned build: product=0xFE01. Signed build: product=0x0001.
- Keys F,F,0,2: unsigned product=0x01FE; signed product=0xFFFE.
- Key 7 pressed during BUSY:
  - product is unchanged by it, overrun=1.
  - The next key in DONE clears overrun and op_b, and sets op_a=0x0k.
- Within one multiply, key_valid and clear_entry asserted together:
  - state IDLE, digit_cnt=0, op_a=0, previous product retained, no prod_valid.
- clr_n low 2 cycles into BUSY:
  - all outputs 0 immediately (asynchronous).
  - After release, a full 1,2,3,4 entry yields 0x03A8.

Source files
------------

// File: rtl/key_operand_mult.sv
// Keypad-driven two-operand entry followed by a WIDTH-cycle shift-add multiplier.
// Build option: define KEYMULT_SIGNED_EN for two's-complement operands and product.
module key_operand_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic [3:0]           key_code,
    input  logic                 key_valid,
    input  logic                 clear_entry,
    output logic [WIDTH-1:0]     op_a,
    output logic [WIDTH-1:0]     op_b,
    output logic [2*WIDTH-1:0]   product,
    output logic [2:0]           digit_cnt,
    output logic                 busy,
    output logic                 prod_valid,
    output logic                 overrun
);
    localparam int DIGITS = WIDTH / 4;
    localparam int IW     = $clog2(WIDTH);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ENTRY_A = 3'd1;
    localparam logic [2:0] S_ENTRY_B = 3'd2;
    localparam logic [2:0] S_BUSY    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]         state_q,  state_d;
    logic [WIDTH-1:0]   op_a_q,   op_a_d;
    logic [WIDTH-1:0]   op_b_q,   op_b_d;
    logic [2*WIDTH-1:0] prod_q,   prod_d;
    logic [3:0]         cnt_q,    cnt_d;
    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [IW-1:0]      iter_q,   iter_d;
    logic               pv_q,     pv_d;
    logic               ovr_q,    ovr_d;

    logic [WIDTH+3:0]   a_ext, b_ext;
    logic [3:0]         cnt_inc;
    logic [2*WIDTH-1:0] partial, acc_step;
    logic               last_iter;

    always_comb begin
        a_ext     = {op_a_q, key_code};
        b_ext     = {op_b_q, key_code};
        cnt_inc   = cnt_q + 4'd1;
        last_iter = (iter_q == IW'(WIDTH - 1));
        partial   = mplier_q[0] ? mcand_q : '0;
`ifdef KEYMULT_SIGNED_EN
        // The multiplier MSB carries negative weight in two's complement.
        acc_step  = last_iter ? (acc_q - partial) : (acc_q + partial);
`else
        acc_step  = acc_q + partial;
`endif

        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        iter_d   = iter_q;
        pv_d     = 1'b0;
        ovr_d    = ovr_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // op_a is already zero in IDLE, so a fresh load equals the shift-in.
                if (key_valid) begin
                    op_a_d  = WIDTH'(key_code);
                    op_b_d  = '0;
                    ovr_d   = 1'b0;
                    cnt_d   = 4'd1;
                    state_d = (DIGITS == 1) ? S_ENTRY_B : S_ENTRY_A;
                end
            end
            S_ENTRY_A: begin
                if (key_valid) begin
                    op_a_d = a_ext[WIDTH-1:0];
                    cnt_d  = cnt_inc;
                    if (cnt_inc == 4'(DIGITS))
                        state_d = S_ENTRY_B;
                end
            end
            S_ENTRY_B: begin
                if (key_valid) begin
                    op_b_d = b_ext[WIDTH-1:0];
                    cnt_d  = cnt_inc;
                    if (cnt_inc == 4'(2 * DIGITS)) begin
                        state_d  = S_BUSY;
                        acc_d    = '0;
`ifdef KEYMULT_SIGNED_EN
                        mcand_d  = {{WIDTH{op_a_q[WIDTH-1]}}, op_a_q};
`else
                        mcand_d  = {{WIDTH{1'b0}}, op_a_q};
`endif
                        mplier_d = b_ext[WIDTH-1:0];
                        iter_d   = '0;
                    end
                end
            end
            S_BUSY: begin
                if (key_valid)
                    ovr_d = 1'b1;
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                iter_d   = iter_q + IW'(1);
                if (last_iter) begin
                    prod_d  = acc_step;
                    pv_d    = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (clear_entry) begin
            state_d = S_IDLE;
            op_a_d  = '0;
            op_b_d  = '0;
            cnt_d   = '0;
            acc_d   = '0;
            ovr_d   = 1'b0;
            pv_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= S_IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            iter_q   <= '0;
            pv_q     <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            iter_q   <= iter_d;
            pv_q     <= pv_d;
            ovr_q    <= ovr_d;
        end
    end

    // The 3-bit count saturates rather than wraps for the widest configuration.
    assign digit_cnt  = (cnt_q > 4'd7) ? 3'd7 : cnt_q[2:0];
    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign product    = prod_q;
    assign busy       = (state_q == S_BUSY);
    assign prod_valid = pv_q;
    assign overrun    = ovr_q;
endmodule
